// File: rtl/ts_mux_scheduler_pkg.sv
// Shared constants and state type for the TS byte mux scheduler.
package ts_pkg;

    localparam int TS_PKT_LEN = 188;
    localparam int TS_NUM_CH  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        XFER
    } sched_state_t;

endpackage

// File: rtl/ts_mux_scheduler_rr_pick.sv
// Rotating priority picker: first request after ptr, wrapping mod 4.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    logic [1:0] idx;

    // Scan farthest-first so the nearest request after ptr wins.
    always_comb begin
        gnt_idx   = 2'd0;
        gnt_valid = 1'b0;
        idx       = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_mux_scheduler.sv
// Packet-granularity weighted round-robin scheduler for the 4-channel
// TS byte mux; one packet per grant, credits refilled from weights.
module ts_mux_scheduler
    import ts_pkg::*;
#(
    parameter int PKT_LEN = TS_PKT_LEN,
    parameter int W_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sched_en,
    input  logic [3:0]             pkt_ready,
    input  logic [4*W_WIDTH-1:0]   weights,
    input  logic                   out_ready,
    output logic [1:0]             mux_ctrl,
    output logic                   en_mux,
    output logic [3:0]             rd_en,
    output logic                   pkt_start,
    output logic                   pkt_end
);

    localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

    sched_state_t         state_q;
    sched_state_t         state_d;
    logic [7:0]           byte_cnt;
    logic [1:0]           rr_ptr;
    logic [W_WIDTH-1:0]   credit [TS_NUM_CH];
    logic [3:0]           eligible;
    logic [3:0]           has_work;
    logic [1:0]           pick_idx;
    logic                 pick_valid;
    logic                 xfer;
    logic                 last_byte;
    logic                 grant;

    always_comb begin
        eligible = '0;
        has_work = '0;
        for (int i = 0; i < TS_NUM_CH; i++) begin
            has_work[i] = pkt_ready[i] &
                          (weights[i*W_WIDTH +: W_WIDTH] != '0);
            eligible[i] = has_work[i] & (credit[i] != '0);
        end
    end

    rr_pick u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    assign xfer      = (state_q == XFER) & out_ready;
    assign last_byte = (byte_cnt == LAST);
    assign grant     = (state_q == IDLE) & sched_en & pick_valid;
    assign pkt_start = en_mux & out_ready & (byte_cnt == 8'd0);
    assign pkt_end   = en_mux & out_ready & last_byte;

    always_comb begin
        rd_en = '0;
        if (state_q == XFER) rd_en[mux_ctrl] = out_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sched_en) begin
                    if (pick_valid)         state_d = XFER;
                    else if (has_work != 0) state_d = RELOAD;
                end
            end
            RELOAD:  state_d = IDLE;
            XFER:    if (xfer && last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            en_mux   <= 1'b0;
            mux_ctrl <= 2'd0;
            byte_cnt <= 8'd0;
            rr_ptr   <= 2'd3;
            for (int i = 0; i < TS_NUM_CH; i++) credit[i] <= '0;
        end else begin
            state_q <= state_d;
            en_mux  <= (state_d == XFER);
            if (grant) begin
                mux_ctrl <= pick_idx;
                byte_cnt <= 8'd0;
            end else if (xfer) begin
                byte_cnt <= last_byte ? 8'd0 : byte_cnt + 8'd1;
            end
            if (state_q == RELOAD) begin
                for (int i = 0; i < TS_NUM_CH; i++)
                    credit[i] <= weights[i*W_WIDTH +: W_WIDTH];
            end else if (xfer && last_byte) begin
                rr_ptr <= mux_ctrl;
                if (credit[mux_ctrl] != '0)
                    credit[mux_ctrl] <= credit[mux_ctrl] - 1'b1;
            end
        end
    end

endmodule
